// File: rtl/smac_pkg.sv
// Shared types and width helpers for the SMAC accumulator stage.
// Width functions let the top derive its bus sizes from array geometry.
package smac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } acc_state_t;

    // Width of one M-lane partial sum: product bits plus lane growth.
    function automatic int calc_psw(int m, int pa, int pw);
        return pa + pw + $clog2(m);
    endfunction

    // Accumulator width wide enough to never wrap over max_tiles sums.
    function automatic int calc_acc_w(int psw, int max_tiles);
        return psw + $clog2(max_tiles);
    endfunction

endpackage

// File: rtl/smac_requant.sv
// Requantiser: logical right shift then unsigned saturation to OUT_W.
// Purely combinational; the caller registers the result.
module smac_requant #(
    parameter  int ACC_W = 26,
    parameter  int OUT_W = 16,
    localparam int SH_W  = $clog2(ACC_W)
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [SH_W-1:0]  shift,
    output logic [OUT_W-1:0] data,
    output logic             sat
);

    logic [ACC_W-1:0] shifted;

    // Shifts at or beyond the accumulator width flush everything out.
    always_comb begin
        shifted = '0;
        if (int'(shift) < ACC_W) begin
            shifted = acc >> shift;
        end
    end

    generate
        if (ACC_W > OUT_W) begin : g_sat
            // Any set bit above the output field means the value is clipped.
            always_comb begin
                sat  = |shifted[ACC_W-1:OUT_W];
                data = sat ? '1 : shifted[OUT_W-1:0];
            end
        end else begin : g_nosat
            // Output field can hold every shifted value.
            always_comb begin
                sat  = 1'b0;
                data = OUT_W'(shifted);
            end
        end
    endgenerate

endmodule

// File: rtl/smac_accumulator.sv
// Accumulates n_tiles partial sums into a dot product and hands the
// requantised result downstream over a valid/ready handshake.
module smac_accumulator
    import smac_pkg::*;
#(
    parameter  int M         = 64,
    parameter  int Pa        = 8,
    parameter  int Pw        = 4,
    parameter  int MAX_TILES = 256,
    parameter  int OUT_W     = 16,
    localparam int PSW       = calc_psw(M, Pa, Pw),
    localparam int ACC_W     = calc_acc_w(PSW, MAX_TILES),
    localparam int NT_W      = $clog2(MAX_TILES) + 1,
    localparam int SH_W      = $clog2(ACC_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NT_W-1:0]  n_tiles,
    input  logic [SH_W-1:0]  shift,
    input  logic             ps_valid,
    input  logic [PSW-1:0]   ps_data,
    output logic             ps_ready,
    output logic             busy,
    output logic             cfg_err,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [OUT_W-1:0] res_data,
    output logic             res_sat
);

    acc_state_t state;
    acc_state_t state_nxt;

    logic [NT_W-1:0]  n_lat;
    logic [SH_W-1:0]  sh_lat;
    logic [NT_W-1:0]  cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;

    logic             cfg_ok;
    logic             accept;
    logic             beat;
    logic             last;
    logic             hs;

    logic [OUT_W-1:0] rq_data;
    logic             rq_sat;

    assign ps_ready = (state == ACC);
    assign busy     = (state != IDLE);

    assign cfg_ok   = (n_tiles != '0) &&
                      (n_tiles <= NT_W'(MAX_TILES));
    assign accept   = (state == IDLE) && start && cfg_ok;

    assign beat     = ps_valid && ps_ready;
    assign acc_next = acc + ACC_W'(ps_data);
    assign last     = beat && (cnt == n_lat - NT_W'(1));
    assign hs       = res_valid && res_ready;

    smac_requant #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_requant (
        .acc   (acc_next),
        .shift (sh_lat),
        .data  (rq_data),
        .sat   (rq_sat)
    );

    // Next-state: job accept, last beat, and result handoff.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = ACC;
            ACC:  if (last)   state_nxt = OUT;
            OUT:  if (hs)     state_nxt = IDLE;
            default:          state_nxt = IDLE;
        endcase
    end

    // State register; reset discards any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Job configuration is captured only on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_lat  <= '0;
            sh_lat <= '0;
        end else if (accept) begin
            n_lat  <= n_tiles;
            sh_lat <= shift;
        end
    end

    // Running sum and beat count; gaps leave both untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= '0;
            cnt <= '0;
        end else if (beat) begin
            acc <= acc_next;
            cnt <= cnt + NT_W'(1);
        end
    end

    // Result register: loaded on the last beat, held until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_sat   <= 1'b0;
        end else if (last) begin
            res_valid <= 1'b1;
            res_data  <= rq_data;
            res_sat   <= rq_sat;
        end else if (hs) begin
            res_valid <= 1'b0;
        end
    end

    // Single-cycle flag for a start rejected while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= (state == IDLE) && start && !cfg_ok;
        end
    end

endmodule

// File: tb/tb_smac_accumulator.sv
// Bench for smac_accumulator: directed jobs plus random jobs checked
// against a sum-then-requantise reference model.
module tb_smac_accumulator;

    localparam int PSW   = 18;
    localparam int ACC_W = 26;
    localparam int OUT_W = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [8:0]  n_tiles;
    logic [4:0]  shift;
    logic        ps_valid;
    logic [17:0] ps_data;
    logic        ps_ready;
    logic        busy;
    logic        cfg_err;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_sat;

    int passed = 0;
    int total  = 0;
    int unsigned q[$];

    smac_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .n_tiles   (n_tiles),
        .shift     (shift),
        .ps_valid  (ps_valid),
        .ps_data   (ps_data),
        .ps_ready  (ps_ready),
        .busy      (busy),
        .cfg_err   (cfg_err),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_sat   (res_sat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: full dot product, shift, clip. Returns {sat, data}.
    function automatic logic [16:0] model(longint unsigned sum, int sh);
        longint unsigned v;
        logic [16:0] r;
        if (sh >= ACC_W) return 17'd0;
        v = sum >> sh;
        if (v > (64'd1 << OUT_W) - 1) return {1'b1, 16'hFFFF};
        r = {1'b0, 16'(v)};
        return r;
    endfunction

    // Runs one job with the beats in q, then consumes the result.
    task automatic do_job(string tag, int sh, int gap_lo, int gap_hi,
                          int hold, bit hold_ps, bit inj, bit hs_start);
        longint unsigned sum = 0;
        logic [16:0] exp;
        int n = q.size();
        n_tiles = 9'(n);
        shift   = 5'(sh);
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check({tag, ".busy"}, 64'(busy), 64'd1);
        check({tag, ".ps_ready"}, 64'(ps_ready), 64'd1);
        for (int i = 0; i < n; i++) begin
            int g = $urandom_range(gap_hi, gap_lo);
            for (int k = 0; k < g; k++) begin
                ps_valid = 1'b0;
                tick();
            end
            if (inj && i == 1) begin
                start   = 1'b1;
                n_tiles = 9'd3;
                shift   = 5'(sh ^ 7);
            end
            ps_valid = 1'b1;
            ps_data  = 18'(q[i]);
            sum += q[i];
            tick();
            ps_valid = 1'b0;
            if (inj && i == 1) begin
                start = 1'b0;
                check({tag, ".inj_cfg_err"}, 64'(cfg_err), 64'd0);
                check({tag, ".inj_busy"}, 64'(busy), 64'd1);
            end
            if (i < n - 1 && n <= 16) begin
                check({tag, ".early_valid"}, 64'(res_valid), 64'd0);
            end
        end
        exp = model(sum, sh);
        check({tag, ".res_valid"}, 64'(res_valid), 64'd1);
        check({tag, ".res_data"}, 64'(res_data), 64'(exp[15:0]));
        check({tag, ".res_sat"}, 64'(res_sat), 64'(exp[16]));
        check({tag, ".out_ps_ready"}, 64'(ps_ready), 64'd0);
        for (int k = 0; k < hold; k++) begin
            ps_valid = hold_ps;
            ps_data  = 18'($urandom);
            tick();
            check({tag, ".hold_valid"}, 64'(res_valid), 64'd1);
            check({tag, ".hold_data"}, 64'(res_data), 64'(exp[15:0]));
            check({tag, ".hold_ps_ready"}, 64'(ps_ready), 64'd0);
        end
        ps_valid  = 1'b0;
        res_ready = 1'b1;
        if (hs_start) begin
            start   = 1'b1;
            n_tiles = 9'd2;
        end
        tick();
        res_ready = 1'b0;
        start     = 1'b0;
        check({tag, ".done_valid"}, 64'(res_valid), 64'd0);
        check({tag, ".done_busy"}, 64'(busy), 64'd0);
        check({tag, ".kept_data"}, 64'(res_data), 64'(exp[15:0]));
        if (hs_start) begin
            check({tag, ".hs_cfg_err"}, 64'(cfg_err), 64'd0);
        end
        q.delete();
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        n_tiles   = '0;
        shift     = '0;
        ps_valid  = 1'b0;
        ps_data   = '0;
        res_ready = 1'b0;
        tick();
        tick();
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.ps_ready", 64'(ps_ready), 64'd0);
        check("rst.res_valid", 64'(res_valid), 64'd0);
        check("rst.res_data", 64'(res_data), 64'd0);
        check("rst.cfg_err", 64'(cfg_err), 64'd0);
        rst_n = 1'b1;
        tick();

        q = '{10, 20, 30, 40};
        do_job("t1", 0, 0, 0, 0, 0, 0, 0);

        q = '{10, 20, 30, 40};
        do_job("t2", 0, 3, 3, 0, 0, 0, 0);

        q = '{5, 6, 7};
        do_job("t3", 0, 0, 1, 5, 1, 0, 0);

        for (int i = 0; i < 256; i++) q.push_back(262143);
        do_job("t4a", 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 256; i++) q.push_back(262143);
        do_job("t4b", 10, 0, 0, 0, 0, 0, 0);

        n_tiles = 9'd0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check("t5.cfg_err0", 64'(cfg_err), 64'd1);
        check("t5.busy0", 64'(busy), 64'd0);
        tick();
        check("t5.cfg_err_pulse", 64'(cfg_err), 64'd0);
        n_tiles = 9'd257;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check("t5.cfg_err257", 64'(cfg_err), 64'd1);
        check("t5.busy257", 64'(busy), 64'd0);
        tick();

        q = '{10, 20, 30, 40};
        do_job("t5inj", 0, 0, 1, 0, 0, 1, 0);

        q = '{1000, 2000};
        do_job("hs_start", 2, 0, 0, 1, 0, 0, 1);
        check("hs_start.idle_ready", 64'(ps_ready), 64'd0);

        q = '{262143};
        do_job("sh26", 26, 0, 0, 0, 0, 0, 0);
        q = '{262143};
        do_job("sh31", 31, 0, 0, 0, 0, 0, 0);

        q = '{100, 200, 300, 400};
        do_job("pre6", 0, 0, 0, 0, 0, 0, 0);
        n_tiles  = 9'd4;
        shift    = 5'd0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        ps_valid = 1'b1;
        ps_data  = 18'd5;
        tick();
        tick();
        ps_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t6.busy", 64'(busy), 64'd0);
        check("t6.ps_ready", 64'(ps_ready), 64'd0);
        check("t6.res_valid", 64'(res_valid), 64'd0);
        check("t6.res_data", 64'(res_data), 64'd0);
        check("t6.res_sat", 64'(res_sat), 64'd0);
        check("t6.cfg_err", 64'(cfg_err), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        q = '{7};
        do_job("t6b", 0, 0, 0, 0, 0, 0, 0);

        for (int j = 0; j < 10; j++) begin
            int n = $urandom_range(12, 1);
            for (int i = 0; i < n; i++) q.push_back($urandom_range(262143, 0));
            do_job("rnd", $urandom_range(31, 0), 0, 2,
                   $urandom_range(3, 0), 1'($urandom_range(1, 0)), 0, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
